// File: rtl/lsu_pkg.sv
// LSU store-line shared definitions: line geometry, controller state
// encoding and the line bundle handed to the D-side line writer.
package lsu_pkg;

    localparam int LSU_LINE_WORDS = 8;
    localparam int LSU_WORD_W     = 32;
    localparam int LSU_ADDR_W     = 32;
    localparam int LSU_LINE_OFS   = $clog2(LSU_LINE_WORDS) + 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } st_state_e;

    typedef struct packed {
        logic [LSU_ADDR_W-1:0]                addr;
        logic [LSU_LINE_WORDS*LSU_WORD_W-1:0] data;
        logic [LSU_LINE_WORDS*4-1:0]          be;
    } line_t;

endpackage

// File: rtl/lsu_word_steer.sv
// Lane steering for one store word: decodes the lane index into per-byte
// write strobes across the line and replicates the word onto every lane.
// Ports: en (store accepted), lane (word index within the line),
//        data/be (store word and its byte enables),
//        byte_we (WORDS*4 strobes, only the addressed lane may be set),
//        wdata (data replicated WORDS times).
module lsu_word_steer
    import lsu_pkg::*;
#(
    parameter int WORDS = LSU_LINE_WORDS,
    parameter int DW    = LSU_WORD_W,
    parameter int LW    = $clog2(WORDS)
) (
    input  logic                en,
    input  logic [LW-1:0]       lane,
    input  logic [DW-1:0]       data,
    input  logic [3:0]          be,
    output logic [WORDS*4-1:0]  byte_we,
    output logic [WORDS*DW-1:0] wdata
);

    assign wdata = {WORDS{data}};

    always_comb begin
        byte_we = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (en && (lane == LW'(w))) begin
                byte_we[w*4 +: 4] = be;
            end
        end
    end

endmodule

// File: rtl/lsu_store_line_ctrl.sv
// LSU store-line controller: gathers store words into one line buffer with
// byte-enable merge, then hands the line to the D-side writer (valid/ready).
// Ports: clk_i, rst_i (async, active-high);
//        st_valid_i/st_ready_o/st_addr_i/st_data_i/st_be_i : store request;
//        flush_i : drain a partially filled line;
//        line_valid_o/line_ready_i/line_addr_o/line_data_o/line_be_o : line out;
//        busy_o : controller not idle.
// Optional macro LSU_STORE_TIMEOUT_EN: drain a FILL line after TIMEOUT
// idle cycles.
module lsu_store_line_ctrl
    import lsu_pkg::*;
#(
    parameter int WORDS   = LSU_LINE_WORDS,
    parameter int DW      = LSU_WORD_W,
    parameter int AW      = LSU_ADDR_W,
    parameter int TIMEOUT = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                st_valid_i,
    output logic                st_ready_o,
    input  logic [AW-1:0]       st_addr_i,
    input  logic [DW-1:0]       st_data_i,
    input  logic [3:0]          st_be_i,
    input  logic                flush_i,
    output logic                line_valid_o,
    input  logic                line_ready_i,
    output logic [AW-1:0]       line_addr_o,
    output logic [WORDS*DW-1:0] line_data_o,
    output logic [WORDS*4-1:0]  line_be_o,
    output logic                busy_o
);

    localparam int OFS = $clog2(WORDS) + 2;
    localparam int LW  = OFS - 2;
    localparam int TW  = AW - OFS;
    localparam int NB  = WORDS * 4;

    localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
    localparam logic [1:0] S_FILL  = 2'(ST_FILL);
    localparam logic [1:0] S_DRAIN = 2'(ST_DRAIN);

    logic [1:0]          state_q;
    logic [1:0]          state_n;
    logic [TW-1:0]       tag_q;
    logic [WORDS*DW-1:0] data_q;
    logic [WORDS*DW-1:0] data_m;
    logic [WORDS*DW-1:0] wdata;
    logic [NB-1:0]       be_q;
    logic [NB-1:0]       be_m;
    logic [NB-1:0]       byte_we;
    logic                tag_hit;
    logic                be_full;
    logic                accept;
    logic                drain_req;
    logic                tmo;
    logic                addr_lo_unused;

    assign addr_lo_unused = ^st_addr_i[1:0];

    assign tag_hit = (st_addr_i[AW-1:OFS] == tag_q);
    assign be_full = &be_q;

    always_comb begin
        st_ready_o = 1'b0;
        unique case (state_q)
            S_IDLE:  st_ready_o = ~rst_i;
            S_FILL:  st_ready_o = tag_hit & ~be_full;
            default: st_ready_o = 1'b0;
        endcase
    end

    assign accept = st_valid_i & st_ready_o;

    lsu_word_steer #(
        .WORDS (WORDS),
        .DW    (DW),
        .LW    (LW)
    ) u_steer (
        .en      (accept),
        .lane    (st_addr_i[OFS-1:2]),
        .data    (st_data_i),
        .be      (st_be_i),
        .byte_we (byte_we),
        .wdata   (wdata)
    );

    // Byte merge: enabled bytes take the new word, the rest keep old data.
    assign be_m = be_q | byte_we;

    always_comb begin
        data_m = data_q;
        for (int b = 0; b < NB; b++) begin
            if (byte_we[b]) begin
                data_m[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
    end

`ifdef LSU_STORE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT);

    logic [CW-1:0] cnt_q;

    assign tmo = (cnt_q == CW'(TIMEOUT - 1));

    // Counts FILL cycles since the last accepted store; zero outside FILL
    // so entering FILL always starts from a cleared count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if ((state_q != S_FILL) || accept) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    localparam int TIMEOUT_UNUSED = TIMEOUT;

    assign tmo = 1'b0;
`endif

    // A tag miss drains without accepting; the store is retried later.
    assign drain_req = (st_valid_i & ~tag_hit) | (&be_m) | flush_i | tmo;

    always_comb begin
        state_n = state_q;
        unique case (state_q)
            S_IDLE:  if (accept) state_n = S_FILL;
            S_FILL:  if (drain_req) state_n = S_DRAIN;
            S_DRAIN: if (line_ready_i) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            tag_q   <= '0;
            data_q  <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_n;
            if ((state_q == S_IDLE) && accept) begin
                tag_q <= st_addr_i[AW-1:OFS];
            end
            if ((state_q == S_DRAIN) && line_ready_i) begin
                data_q <= '0;
                be_q   <= '0;
            end else if (accept) begin
                data_q <= data_m;
                be_q   <= be_m;
            end
        end
    end

    assign line_valid_o = (state_q == S_DRAIN);
    assign line_addr_o  = {tag_q, {OFS{1'b0}}};
    assign line_data_o  = data_q;
    assign line_be_o    = be_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_lsu_store_line_ctrl.sv
// Self-checking bench for lsu_store_line_ctrl: directed scenarios plus
// randomized traffic against a line-level reference model.
module tb_lsu_store_line_ctrl;
    import lsu_pkg::*;

    localparam int TB_TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         st_valid_i;
    logic         st_ready_o;
    logic [31:0]  st_addr_i;
    logic [31:0]  st_data_i;
    logic [3:0]   st_be_i;
    logic         flush_i;
    logic         line_valid_o;
    logic         line_ready_i;
    logic [31:0]  line_addr_o;
    logic [255:0] line_data_o;
    logic [31:0]  line_be_o;
    logic         busy_o;

    int passed = 0;
    int total  = 0;

    // Reference model: the line being collected and the line on offer.
    bit          m_open;
    bit          m_out;
    logic [26:0] m_tag;
    logic [31:0] m_data [8];
    logic [3:0]  m_be [8];
    line_t       m_line;
    int          m_idle;

    always #5 clk = ~clk;

    lsu_store_line_ctrl #(
        .WORDS   (8),
        .DW      (32),
        .AW      (32),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .st_valid_i   (st_valid_i),
        .st_ready_o   (st_ready_o),
        .st_addr_i    (st_addr_i),
        .st_data_i    (st_data_i),
        .st_be_i      (st_be_i),
        .flush_i      (flush_i),
        .line_valid_o (line_valid_o),
        .line_ready_i (line_ready_i),
        .line_addr_o  (line_addr_o),
        .line_data_o  (line_data_o),
        .line_be_o    (line_be_o),
        .busy_o       (busy_o)
    );

    task automatic model_clear();
        m_open = 1'b0;
        m_out  = 1'b0;
        m_tag  = '0;
        m_idle = 0;
        m_line = '0;
        for (int w = 0; w < 8; w++) begin
            m_data[w] = '0;
            m_be[w]   = '0;
        end
    endtask

    function automatic bit model_ready();
        bit all_be;
        all_be = 1'b1;
        for (int w = 0; w < 8; w++)
            if (m_be[w] != 4'hF) all_be = 1'b0;
        if (m_out) return 1'b0;
        if (!m_open) return 1'b1;
        return (st_addr_i[31:5] == m_tag) && !all_be;
    endfunction

    task automatic drive(input bit v, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         input bit fl, input bit lr);
        st_valid_i   = v;
        st_addr_i    = a;
        st_data_i    = d;
        st_be_i      = be;
        flush_i      = fl;
        line_ready_i = lr;
    endtask

    // Advance one clock, updating the model from the inputs presented.
    task automatic tick();
        bit acc;
        bit was_open;
        bit miss;
        bit tmo;
        bit all_be;
        int ln;
        if (m_out) begin
            if (line_ready_i) model_clear();
        end else begin
            was_open = m_open;
            acc  = st_valid_i && model_ready();
            miss = st_valid_i && m_open && (st_addr_i[31:5] != m_tag);
            tmo  = 1'b0;
`ifdef LSU_STORE_TIMEOUT_EN
            tmo = m_open && (m_idle == TB_TIMEOUT - 1);
`endif
            if (acc) begin
                if (!m_open) begin
                    m_open = 1'b1;
                    m_tag  = st_addr_i[31:5];
                end
                m_idle = 0;
                ln = int'(st_addr_i[4:2]);
                for (int b = 0; b < 4; b++)
                    if (st_be_i[b]) m_data[ln][8*b +: 8] = st_data_i[8*b +: 8];
                m_be[ln] = m_be[ln] | st_be_i;
            end else if (was_open) begin
                m_idle++;
            end
            all_be = 1'b1;
            for (int w = 0; w < 8; w++)
                if (m_be[w] != 4'hF) all_be = 1'b0;
            if (was_open && (miss || all_be || flush_i || tmo)) begin
                m_out  = 1'b1;
                m_open = 1'b0;
                m_line.addr = {m_tag, 5'b0};
                for (int w = 0; w < 8; w++) begin
                    m_line.data[w*32 +: 32] = m_data[w];
                    m_line.be[w*4 +: 4]     = m_be[w];
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        drive(1, 32'h1000, 32'h1, 4'hF, 1, 1);
        model_clear();
        #1;
        total++;
        if (st_ready_o !== 1'b0)
            $display("FAIL reset_ready got %b want 0", st_ready_o);
        else passed++;
        total++;
        if ({line_valid_o, busy_o, line_addr_o} !== 34'h0)
            $display("FAIL reset_ctl got v=%b b=%b a=%h want 0",
                     line_valid_o, busy_o, line_addr_o);
        else passed++;
        total++;
        if ({line_data_o, line_be_o} !== 288'h0)
            $display("FAIL reset_line got be=%h want 0", line_be_o);
        else passed++;
        apply_reset();
        total++;
        if (st_ready_o !== 1'b1)
            $display("FAIL reset_release_ready got %b want 1", st_ready_o);
        else passed++;
    endtask

    task automatic test_full_line();
        logic [255:0] exp_d;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1, 32'h1000 + 32'(4*i), 32'(i), 4'hF, 0, 0);
            #1;
            total++;
            if (st_ready_o !== 1'b1)
                $display("FAIL full_ready%0d got %b want 1", i, st_ready_o);
            else passed++;
            tick();
        end
        for (int w = 0; w < 8; w++) exp_d[w*32 +: 32] = 32'(w);
        drive(1, 32'h1000, 32'h9, 4'hF, 0, 0);
        #1;
        total++;
        if ({line_valid_o, st_ready_o} !== 2'b10)
            $display("FAIL full_drain got v=%b r=%b want v=1 r=0",
                     line_valid_o, st_ready_o);
        else passed++;
        total++;
        if (line_addr_o !== 32'h1000 || line_data_o !== exp_d ||
            line_be_o !== 32'hFFFF_FFFF)
            $display("FAIL full_line got a=%h be=%h d=%h want a=1000 be=ffffffff d=%h",
                     line_addr_o, line_be_o, line_data_o, exp_d);
        else passed++;
        repeat (3) tick();
        total++;
        if ({line_valid_o, st_ready_o} !== 2'b10)
            $display("FAIL full_hold got v=%b r=%b want v=1 r=0",
                     line_valid_o, st_ready_o);
        else passed++;
        drive(0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if ({line_valid_o, st_ready_o, busy_o, line_be_o} !== {3'b010, 32'h0})
            $display("FAIL full_after_hs got v=%b r=%b b=%b be=%h want 0 1 0 0",
                     line_valid_o, st_ready_o, busy_o, line_be_o);
        else passed++;
    endtask

    task automatic test_merge();
        apply_reset();
        drive(1, 32'h2004, 32'hAAAA_BBBB, 4'h3, 0, 0);
        tick();
        drive(1, 32'h2004, 32'h1111_2222, 4'hC, 0, 0);
        #1;
        total++;
        if (st_ready_o !== 1'b1)
            $display("FAIL merge_ready got %b want 1", st_ready_o);
        else passed++;
        tick();
        drive(0, 0, 0, 0, 1, 0);
        tick();
        total++;
        if (line_valid_o !== 1'b1 || line_addr_o !== 32'h2000 ||
            line_data_o !== {192'h0, 32'h1111_BBBB, 32'h0} ||
            line_be_o !== 32'h0000_00F0)
            $display("FAIL merge_line got v=%b a=%h be=%h d=%h want word1=1111bbbb be=f0",
                     line_valid_o, line_addr_o, line_be_o, line_data_o);
        else passed++;
        drive(0, 0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_tag_miss();
        apply_reset();
        drive(1, 32'h3000, 32'h55, 4'hF, 0, 0);
        tick();
        drive(1, 32'h3020, 32'h66, 4'hF, 0, 0);
        #1;
        total++;
        if (st_ready_o !== 1'b0)
            $display("FAIL miss_ready got %b want 0", st_ready_o);
        else passed++;
        tick();
        total++;
        if (line_valid_o !== 1'b1 || line_addr_o !== 32'h3000 ||
            line_data_o !== 256'h55 || line_be_o !== 32'hF)
            $display("FAIL miss_line got v=%b a=%h be=%h want v=1 a=3000 be=f",
                     line_valid_o, line_addr_o, line_be_o);
        else passed++;
        drive(1, 32'h3020, 32'h66, 4'hF, 0, 1);
        tick();
        drive(1, 32'h3020, 32'h66, 4'hF, 0, 0);
        #1;
        total++;
        if (st_ready_o !== 1'b1)
            $display("FAIL miss_retry_ready got %b want 1", st_ready_o);
        else passed++;
        tick();
        drive(0, 0, 0, 0, 1, 0);
        tick();
        total++;
        if (line_valid_o !== 1'b1 || line_addr_o !== 32'h3020 ||
            line_data_o !== 256'h66 || line_be_o !== 32'hF)
            $display("FAIL miss_newline got v=%b a=%h be=%h want v=1 a=3020 be=f",
                     line_valid_o, line_addr_o, line_be_o);
        else passed++;
        drive(0, 0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_drain_hold_reset();
        int bad;
        apply_reset();
        drive(1, 32'h4008, 32'hDEAD, 4'hF, 0, 0);
        tick();
        drive(0, 0, 0, 0, 1, 0);
        tick();
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h4000, 32'h1234, 4'hF, 0, 0);
            #1;
            if (line_valid_o !== 1'b1 || st_ready_o !== 1'b0 ||
                line_addr_o !== 32'h4000 ||
                line_data_o !== {160'h0, 32'hDEAD, 64'h0} ||
                line_be_o !== 32'h0000_0F00) bad++;
            tick();
        end
        total++;
        if (bad != 0)
            $display("FAIL hold_stable got %0d bad cycles want 0", bad);
        else passed++;
        rst_i = 1'b1;
        #2;
        total++;
        if ({line_valid_o, busy_o, st_ready_o} !== 3'b000)
            $display("FAIL hold_rst got v=%b b=%b r=%b want 000",
                     line_valid_o, busy_o, st_ready_o);
        else passed++;
        rst_i = 1'b0;
        model_clear();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if ({line_valid_o, busy_o, st_ready_o, line_be_o} !== {3'b001, 32'h0})
            $display("FAIL hold_post_rst got v=%b b=%b r=%b be=%h want 0 0 1 0",
                     line_valid_o, busy_o, st_ready_o, line_be_o);
        else passed++;
        tick();
    endtask

    task automatic test_flush();
        int seen;
        apply_reset();
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, 0);
            tick();
            if (line_valid_o !== 1'b0 || busy_o !== 1'b0) seen++;
        end
        total++;
        if (seen != 0)
            $display("FAIL flush_idle got %0d active cycles want 0", seen);
        else passed++;
        drive(1, 32'h5000, 32'h1, 4'hF, 0, 0);
        tick();
        drive(1, 32'h5010, 32'h77, 4'hF, 1, 0);
        #1;
        total++;
        if (st_ready_o !== 1'b1)
            $display("FAIL flush_store_ready got %b want 1", st_ready_o);
        else passed++;
        tick();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        total++;
        if (line_valid_o !== 1'b1 ||
            line_data_o !== {96'h0, 32'h77, 96'h0, 32'h1} ||
            line_be_o !== 32'h000F_000F)
            $display("FAIL flush_line got v=%b be=%h d=%h want be=000f000f",
                     line_valid_o, line_be_o, line_data_o);
        else passed++;
        drive(0, 0, 0, 0, 0, 1);
        tick();
    endtask

`ifdef LSU_STORE_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        int seen;
        apply_reset();
        drive(1, 32'h7000, 32'h3, 4'hF, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        n = 0;
        while (line_valid_o !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        total++;
        if (n != TB_TIMEOUT)
            $display("FAIL timeout_cycles got %0d want %0d", n, TB_TIMEOUT);
        else passed++;
        drive(0, 0, 0, 0, 0, 1);
        tick();
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1, 32'h7000 + 32'(4*k), 32'(k), 4'h1, 0, 0);
            tick();
            drive(0, 0, 0, 0, 0, 0);
            for (int j = 0; j < 14; j++) begin
                tick();
                if (line_valid_o !== 1'b0) seen++;
            end
        end
        total++;
        if (seen != 0 || busy_o !== 1'b1)
            $display("FAIL timeout_refresh got %0d drain cycles busy=%b want 0 1",
                     seen, busy_o);
        else passed++;
        drive(0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick();
    endtask
`else
    task automatic test_no_timeout();
        int seen;
        apply_reset();
        drive(1, 32'h7000, 32'h3, 4'hF, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (line_valid_o !== 1'b0) seen++;
        end
        total++;
        if (seen != 0 || busy_o !== 1'b1)
            $display("FAIL no_timeout got %0d drain cycles busy=%b want 0 1",
                     seen, busy_o);
        else passed++;
        drive(0, 0, 0, 0, 1, 0);
        tick();
        drive(0, 0, 0, 0, 0, 1);
        tick();
    endtask
`endif

    task automatic test_random();
        logic [31:0] base;
        logic [3:0]  be;
        int          errs;
        int          lines;
        apply_reset();
        errs  = 0;
        lines = 0;
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 3))
                0:       base = 32'h6020;
                1:       base = 32'h6040;
                default: base = 32'h6000;
            endcase
            be = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            drive($urandom_range(0, 9) < 7,
                  base + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3)),
                  $urandom, be,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 1) == 1);
            #1;
            total++;
            if (st_ready_o !== model_ready() || line_valid_o !== m_out) begin
                errs++;
                $display("FAIL rand_ctl%0d got r=%b v=%b want r=%b v=%b",
                         i, st_ready_o, line_valid_o, model_ready(), m_out);
            end else passed++;
            if (m_out) begin
                total++;
                if ({line_addr_o, line_data_o, line_be_o} !== m_line) begin
                    errs++;
                    $display("FAIL rand_line%0d got a=%h be=%h want a=%h be=%h",
                             i, line_addr_o, line_be_o, m_line.addr, m_line.be);
                end else passed++;
                if (line_ready_i) lines++;
            end
            if (errs > 20) break;
            tick();
        end
        total++;
        if (lines < 10)
            $display("FAIL rand_lines got %0d lines want >=10", lines);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_full_line();
        test_merge();
        test_tag_miss();
        test_drain_hold_reset();
        test_flush();
`ifdef LSU_STORE_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
